// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memIO bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_FC  = 1'b1;

    typedef struct packed {
        logic vld;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag delay line: carries {valid, port id} alongside the memory read latency.
// Latency: DEPTH cycles (DEPTH=0 is a combinational pass-through).
// Backpressure: none; one tag enters and one leaves every cycle.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign tag_out = tag_in;
        end else begin : g_pipe
            rd_tag_t stage [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= tag_in;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign tag_out = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU / fractal-fetcher arbiter for the single memIO bus; MEM_ARB_RR_EN selects round-robin.
// Latency: grant one cycle after request; read data RD_LAT+1 cycles after the address beat.
// Backpressure: a port waits with req high until its registered grant; HOLD_MAX bounds ownership.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic [31:0] bus_rdata
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    arb_state_t state;
    arb_state_t nxt_state;
    logic [3:0] hold_cnt;
    logic [3:0] nxt_cnt;
    logic [3:0] hold_sat;
    logic       tie_win1;
    logic       preempt0;
    logic       preempt1;

    assign hold_sat = (hold_cnt == 4'hF) ? hold_cnt : hold_cnt + 4'd1;
    assign preempt1 = req0 && (hold_cnt == HOLD_LAST);

`ifdef MEM_ARB_RR_EN
    logic last_owner;

    // On a tie, the port that did not own the bus most recently wins.
    assign tie_win1 = (last_owner == PORT_CPU);
    assign preempt0 = req1 && (hold_cnt == HOLD_LAST);
`else
    assign tie_win1 = 1'b0;
    assign preempt0 = 1'b0;
`endif

    always_comb begin
        nxt_state = state;
        nxt_cnt   = hold_sat;
        case (state)
            ARB_IDLE: begin
                nxt_cnt = '0;
                if (req0 && req1)  nxt_state = tie_win1 ? ARB_OWN1 : ARB_OWN0;
                else if (req0)     nxt_state = ARB_OWN0;
                else if (req1)     nxt_state = ARB_OWN1;
            end
            ARB_OWN0: begin
                // A request drop takes precedence over hold expiry in the same cycle.
                if (!req0) begin
                    nxt_state = req1 ? ARB_OWN1 : ARB_IDLE;
                    nxt_cnt   = '0;
                end else if (preempt0) begin
                    nxt_state = ARB_OWN1;
                    nxt_cnt   = '0;
                end
            end
            ARB_OWN1: begin
                if (!req1) begin
                    nxt_state = req0 ? ARB_OWN0 : ARB_IDLE;
                    nxt_cnt   = '0;
                end else if (preempt1) begin
                    nxt_state = ARB_OWN0;
                    nxt_cnt   = '0;
                end
            end
            default: begin
                nxt_state = ARB_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            hold_cnt <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner <= PORT_FC;
`endif
        end else begin
            state    <= nxt_state;
            hold_cnt <= nxt_cnt;
            gnt0     <= (nxt_state == ARB_OWN0);
            gnt1     <= (nxt_state == ARB_OWN1);
`ifdef MEM_ARB_RR_EN
            if (nxt_state == ARB_OWN0)      last_owner <= PORT_CPU;
            else if (nxt_state == ARB_OWN1) last_owner <= PORT_FC;
`endif
        end
    end

    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_we    = 1'b0;
        if (gnt0) begin
            bus_addr  = addr0;
            bus_wdata = wdata0;
            bus_we    = we0 & req0;
        end else if (gnt1) begin
            bus_addr  = addr1;
            bus_wdata = wdata1;
            bus_we    = we1 & req1;
        end
    end

    rd_tag_t tag_in;
    rd_tag_t tag_out;

    // A beat is real only while the owner still requests; a trailing granted cycle issues nothing.
    assign tag_in.vld  = (gnt0 && req0 && !we0) || (gnt1 && req1 && !we1);
    assign tag_in.port = gnt1 ? PORT_FC : PORT_CPU;

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
        end else begin
            rvalid0 <= tag_out.vld && (tag_out.port == PORT_CPU);
            rvalid1 <= tag_out.vld && (tag_out.port == PORT_FC);
            if (tag_out.vld) rdata <= bus_rdata;
        end
    end

endmodule
